// File: rtl/t1_pcs_pkg.sv
// Shared definitions for the 100BASE-T1 PCS transmit/receive symbol paths.
//   - ternary symbol encoding (T_POS / T_ZERO / T_NEG)
//   - transmit mapper FSM state enum
//   - SSD / ESD / underrun-ESD delimiter pair tables
//   - side-stream scrambler tap indices for the idle word Sy[2:0]
package t1_pcs_pkg;

  localparam logic [1:0] T_POS  = 2'b01;
  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_NEG  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_SSD, ST_DATA, ST_ESD} state_t;

  typedef struct packed {
    logic [1:0] ta;
    logic [1:0] tb;
  } tpair_t;

  // Delimiter tables are indexed by the 2-bit counter, so they hold four
  // entries. Only the first SSD_LEN / ESD_LEN entries are ever reached.
  localparam tpair_t SSD_PAIRS [4] = '{
    {T_ZERO, T_ZERO}, {T_ZERO, T_ZERO}, {T_ZERO, T_ZERO}, {T_ZERO, T_ZERO}};
  localparam tpair_t ESD_PAIRS [4] = '{
    {T_ZERO, T_ZERO}, {T_ZERO, T_ZERO}, {T_POS, T_POS}, {T_ZERO, T_ZERO}};
  localparam tpair_t ESD_ERR_PAIRS [4] = '{
    {T_ZERO, T_ZERO}, {T_ZERO, T_ZERO}, {T_NEG, T_NEG}, {T_ZERO, T_ZERO}};

  // Sy[2] = scr[6]^scr[16], Sy[1] = scr[3]^scr[8], Sy[0] = scr[0]
  localparam int SY2_TAP_A = 6;
  localparam int SY2_TAP_B = 16;
  localparam int SY1_TAP_A = 3;
  localparam int SY1_TAP_B = 8;
  localparam int SY0_TAP   = 0;

  function automatic logic [2:0] idle_sy(input logic [32:0] scr);
    return {scr[SY2_TAP_A] ^ scr[SY2_TAP_B],
            scr[SY1_TAP_A] ^ scr[SY1_TAP_B],
            scr[SY0_TAP]};
  endfunction

endpackage

// File: rtl/t1_3b2t_map.sv
// 3B2T mapper: 3-bit scrambled word Sd -> ternary pair (TA, TB).
// Purely combinational; also used by the receive-side demapper checker.
//   i_sd  3-bit scrambled word
//   o_ta  ternary A (01=+1, 00=0, 11=-1)
//   o_tb  ternary B
// (0,0) is never produced here; it is reserved for delimiters.
module t1_3b2t_map
  import t1_pcs_pkg::*;
(
  input  logic [2:0] i_sd,
  output logic [1:0] o_ta,
  output logic [1:0] o_tb
);

  always_comb begin
    o_ta = T_ZERO;
    o_tb = T_ZERO;
    case (i_sd)
      3'b000: begin o_ta = T_NEG;  o_tb = T_NEG;  end
      3'b001: begin o_ta = T_NEG;  o_tb = T_ZERO; end
      3'b010: begin o_ta = T_NEG;  o_tb = T_POS;  end
      3'b011: begin o_ta = T_ZERO; o_tb = T_NEG;  end
      3'b100: begin o_ta = T_POS;  o_tb = T_NEG;  end
      3'b101: begin o_ta = T_POS;  o_tb = T_ZERO; end
      3'b110: begin o_ta = T_POS;  o_tb = T_POS;  end
      3'b111: begin o_ta = T_ZERO; o_tb = T_POS;  end
      default: ;
    endcase
  end

endmodule

// File: rtl/t1_pcs_tx_sym_map.sv
// 100BASE-T1 PCS transmit symbol mapper.
// Frames 3B groups from the 4B3B stage with SSD/ESD, scrambles them with
// the side-stream idle word Sy and maps to ternary pairs, one per strobe.
// Idle periods are filled with mapped Sy. A missing group inside a frame
// terminates it with the underrun ESD variant.
//   clk, rst_n     clock, async active-low reset
//   i_sym_en       symbol strobe
//   i_scr          side-stream scrambler state Scr_n[32:0]
//   o_scr_adv      scrambler advance (= i_sym_en)
//   i_in_valid / i_in_data / i_in_last / o_in_ready   upstream group handshake
//   o_out_valid    1-cycle pulse, TA/TB updated
//   o_out_ta / o_out_tb   ternary pair (held between pulses)
//   o_underrun     pulse with the first underrun ESD pair
module t1_pcs_tx_sym_map
  import t1_pcs_pkg::*;
#(
  parameter int SSD_LEN = 3,  // 1..4
  parameter int ESD_LEN = 3   // 2..4 (underrun path starts at index 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sym_en,
  input  logic [32:0] i_scr,
  output logic        o_scr_adv,
  input  logic        i_in_valid,
  input  logic [2:0]  i_in_data,
  input  logic        i_in_last,
  output logic        o_in_ready,
  output logic        o_out_valid,
  output logic [1:0]  o_out_ta,
  output logic [1:0]  o_out_tb,
  output logic        o_underrun
);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_cnt,   w_cnt_nxt;
  logic       r_err,   w_err_nxt;

  logic [2:0] w_sy, w_sd;
  logic [1:0] w_map_ta, w_map_tb;
  tpair_t     w_pair;
  logic       w_ready, w_underrun;

  // Mapping always uses the pre-advance scrambler state sampled this edge.
  assign w_sy      = idle_sy(i_scr);
  assign w_sd      = (r_state == ST_DATA) ? (i_in_data ^ w_sy) : w_sy;
  assign o_scr_adv = i_sym_en;
  assign o_in_ready = w_ready;

  t1_3b2t_map u_map (
    .i_sd (w_sd),
    .o_ta (w_map_ta),
    .o_tb (w_map_tb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_err   <= 1'b0;
    end else if (i_sym_en) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_pair      = {w_map_ta, w_map_tb};
    w_ready     = 1'b0;
    w_underrun  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_in_valid) begin
          w_state_nxt = ST_SSD;
          w_cnt_nxt   = 2'd0;
        end
      end
      ST_SSD: begin
        w_pair = SSD_PAIRS[r_cnt];
        if (r_cnt == 2'(SSD_LEN - 1)) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      ST_DATA: begin
        if (i_in_valid) begin
          w_ready = i_sym_en;
          if (i_in_last) begin
            w_state_nxt = ST_ESD;
            w_cnt_nxt   = 2'd0;
          end
        end else begin
          // Starved mid-frame: first error-ESD pair goes out now.
          w_pair      = ESD_ERR_PAIRS[0];
          w_underrun  = 1'b1;
          w_state_nxt = ST_ESD;
          w_cnt_nxt   = 2'd1;
          w_err_nxt   = 1'b1;
        end
      end
      ST_ESD: begin
        w_pair = r_err ? ESD_ERR_PAIRS[r_cnt] : ESD_PAIRS[r_cnt];
        if (r_cnt == 2'(ESD_LEN - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 2'd0;
          w_err_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out_valid <= 1'b0;
      o_out_ta    <= T_ZERO;
      o_out_tb    <= T_ZERO;
      o_underrun  <= 1'b0;
    end else begin
      o_out_valid <= i_sym_en;
      o_underrun  <= i_sym_en & w_underrun;
      if (i_sym_en) begin
        o_out_ta <= w_pair.ta;
        o_out_tb <= w_pair.tb;
      end
    end
  end

endmodule

// File: tb/tb_t1_pcs_tx_sym_map.sv
// Randomized + directed bench for t1_pcs_tx_sym_map against a queue-based
// reference model of the framing rules.
module tb_t1_pcs_tx_sym_map;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sym_en, scr_adv;
  logic [32:0] scr;
  logic        in_valid, in_last, in_ready;
  logic [2:0]  in_data;
  logic        out_valid, underrun;
  logic [1:0]  out_ta, out_tb;

  always #5 clk = ~clk;

  t1_pcs_tx_sym_map dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sym_en    (sym_en),
    .i_scr       (scr),
    .o_scr_adv   (scr_adv),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .i_in_last   (in_last),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_out_ta    (out_ta),
    .o_out_tb    (out_tb),
    .o_underrun  (underrun)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_rdy  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---- reference model: pending delimiter queue + in-frame flag ----
  logic [3:0] dq[$];
  bit         in_frame = 0;
  logic [3:0] m_pair   = 4'h0;
  logic [3:0] last_out;

  function automatic logic [1:0] enc(input int v);
    return (v > 0) ? 2'b01 : (v < 0) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [3:0] map3(input logic [2:0] s);
    int a, b;
    a = s[2] ? 1 : -1;
    b = int'(s[1:0]) - 1;
    if (s[1:0] == 2'b11) begin
      a = 0;
      b = s[2] ? 1 : -1;
    end
    return {enc(a), enc(b)};
  endfunction

  function automatic logic [2:0] sy(input logic [32:0] s);
    return {s[6] ^ s[16], s[3] ^ s[8], s[0]};
  endfunction

  task automatic model_reset();
    dq.delete();
    in_frame = 0;
    m_pair   = 4'h0;
  endtask

  // One clock: drive at negedge, check combinational outputs, advance the
  // model, then check registered outputs just after the posedge.
  task automatic cyc(input bit en, input bit v, input logic [2:0] d,
                     input bit last, input logic [32:0] s);
    bit exp_rdy, exp_ur;
    @(negedge clk);
    sym_en = en; in_valid = v; in_data = d; in_last = last; scr = s;
    #1;
    exp_rdy = en && v && in_frame && (dq.size() == 0);
    exp_ur  = 0;
    chk("scr_adv", 32'(scr_adv), 32'(en));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (in_ready) n_rdy++;
    if (en) begin
      if (dq.size() != 0) begin
        m_pair = dq.pop_front();
      end else if (in_frame) begin
        if (v) begin
          m_pair = map3(d ^ sy(s));
          if (last) begin
            in_frame = 0;
            dq.push_back(4'b0000); dq.push_back(4'b0000); dq.push_back(4'b0101);
          end
        end else begin
          exp_ur   = 1;
          in_frame = 0;
          m_pair   = 4'b0000;
          dq.push_back(4'b0000); dq.push_back(4'b1111);
        end
      end else begin
        m_pair = map3(sy(s));
        if (v) begin
          in_frame = 1;
          dq.push_back(4'b0000); dq.push_back(4'b0000); dq.push_back(4'b0000);
        end
      end
    end
    @(posedge clk);
    #1;
    last_out = {out_ta, out_tb};
    chk("out_valid", 32'(out_valid), 32'(en));
    chk("ta", 32'(out_ta), 32'(m_pair[3:2]));
    chk("tb", 32'(out_tb), 32'(m_pair[1:0]));
    chk("underrun", 32'(underrun), 32'(exp_ur));
  endtask

  function automatic logic [32:0] rnd_scr();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[32:0];
  endfunction

  logic [3:0] frame1 [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100,
                             4'b0000, 4'b0000, 4'b0101, 4'b1111};

  initial begin
    rst_n = 1'b0; sym_en = 0; in_valid = 0; in_data = 0; in_last = 0; scr = '0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ta", 32'(out_ta), 0);
    chk("rst_tb", 32'(out_tb), 0);
    chk("rst_underrun", 32'(underrun), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Idle with scr=0: (-1,-1) every symbol.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 3'd0, 0, 33'd0);
      chk("idle0", 32'(last_out), 32'hF);
    end
    cyc(1, 0, 3'd0, 0, 33'h1);
    chk("idle_b0", 32'(last_out), 32'hC);
    cyc(1, 0, 3'd0, 0, 33'h48);
    chk("idle_b36", 32'(last_out), 32'h5);

    // One-group frame, data 101, scr=0.
    n_rdy = 0;
    cyc(1, 1, 3'b101, 1, 33'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, (i < 4), 3'b101, 1, 33'd0);
      chk("frame1", 32'(last_out), 32'(frame1[i]));
    end
    chk("frame1_rdy", 32'(n_rdy), 1);

    // Underrun after two groups.
    cyc(1, 1, 3'd2, 0, rnd_scr());
    repeat (3) cyc(1, 1, 3'd2, 0, rnd_scr());
    repeat (2) cyc(1, 1, 3'($urandom_range(0, 7)), 0, rnd_scr());
    cyc(1, 0, 3'd0, 0, rnd_scr());
    chk("ur_pulse", 32'(underrun), 1);
    repeat (3) cyc(1, 0, 3'd0, 0, rnd_scr());

    // Sparse strobes: every third cycle.
    for (int i = 0; i < 36; i++)
      cyc((i % 3) == 0, 1, 3'($urandom_range(0, 7)), (i == 27), rnd_scr());
    repeat (4) cyc(1, 0, 3'd0, 0, rnd_scr());

    // Reset in the middle of DATA.
    repeat (5) cyc(1, 1, 3'($urandom_range(0, 7)), 0, rnd_scr());
    @(negedge clk);
    sym_en = 0;
    rst_n  = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ta", 32'(out_ta), 0);
    chk("arst_tb", 32'(out_tb), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) cyc(1, 0, 3'd0, 0, rnd_scr());

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0,
          3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, rnd_scr());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/t1_pcs_tx_sym_map.md
# t1_pcs_tx_sym_map

Transmit-side symbol mapper for the 100BASE-T1 PCS. It consumes 3-bit groups from the 4B3B stage and the 33-bit side-stream scrambler state, and emits one scrambled ternary pair (TA, TB) per symbol strobe. It also frames each packet with SSD/ESD and fills idle periods with scrambled idle symbols. It sits between the 4B3B encoder (upstream) and the PMA transmit interface (downstream), and drives the advance strobe of the side-stream scrambler.

## Interface
Parameters:
- SSD_LEN, 3, number of SSD symbol pairs.
- ESD_LEN, 3, number of ESD symbol pairs.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- sym_en  in  1  symbol strobe; one symbol is produced per cycle in which it is high.
- scr  in  33  current side-stream scrambler state (Scr_n[32:0]).
- scr_adv  out  1  scrambler advance; combinationally equal to sym_en.
- in_valid  in  1  upstream group valid.
- in_data  in  3  upstream 3B group.
- in_last  in  1  group is last of frame; qualified by in_valid.
- in_ready  out  1  group accepted this cycle.
- out_valid  out  1  TA/TB updated this cycle.
- out_ta  out  2  ternary A; encoding 2'b01=+1, 2'b00=0, 2'b11=-1.
- out_tb  out  2  ternary B; same encoding.
- underrun  out  1  one-cycle pulse on data starvation inside a frame.

## Operation
- Idle scrambler word: Sy[2:0] = {scr[6]^scr[16], scr[3]^scr[8], scr[0]}.
- Sd[2:0] = in_data ^ Sy in DATA; Sd = Sy in IDLE.
- 3B2T map, Sd -> (TA,TB):
  - 000->(-1,-1), 001->(-1,0), 010->(-1,+1), 011->(0,-1)
  - 100->(+1,-1), 101->(+1,0), 110->(+1,+1), 111->(0,+1)
  - (0,0) is never produced from data; it is reserved for delimiters.
- SSD pairs: (0,0),(0,0),(0,0).
- ESD pairs: (0,0),(0,0),(+1,+1). Underrun ESD pairs: (0,0),(0,0),(-1,-1).
- FSM states: IDLE, SSD, DATA, ESD. A 2-bit index counter cnt is used in SSD/ESD.
  - IDLE: on sym_en, emit mapped Sy. If in_valid, go to SSD with cnt=0. Data is not consumed in IDLE.
  - SSD: on sym_en, emit SSD[cnt]. At cnt==SSD_LEN-1, go to DATA.
  - DATA, sym_en & in_valid: in_ready=1, emit mapped Sd. If in_last, go to ESD with cnt=0.
  - DATA, sym_en & !in_valid: pulse underrun, emit first underrun-ESD pair, go to ESD with cnt=1 and the error flag set.
  - ESD: on sym_en, emit ESD[cnt] (or the error variant). At cnt==ESD_LEN-1, go to IDLE and clear the error flag.
- in_ready = sym_en & (state==DATA) & in_valid. It is never high outside DATA.
- Cycles without sym_en: no state change, no output update, in_ready=0, out_valid=0.
- The scrambler advances on every sym_en in every state. The mapping always uses scr as sampled at that same edge (the pre-advance value).

## Timing
- Reset values: out_valid=0, out_ta=00, out_tb=00, underrun=0, state=IDLE, cnt=0, error flag=0.
- Reset mid-frame aborts immediately. No ESD is emitted after release.
- Latency: out_ta/out_tb/out_valid are registered and update the cycle after the sym_en edge (1 clk).
- out_valid is a 1-cycle pulse per symbol. out_ta/out_tb hold their value between pulses.
- underrun is registered and coincident with the out_valid of the underrun ESD pair.
- Back-to-back frames: after the last ESD pair, at least one IDLE symbol is emitted before the next SSD.
- in_last with in_valid on the final group: that group is mapped normally. The ESD follows on the next three strobes.
- Minimum frame is one group: SSD(3) + 1 + ESD(3).

## Structure
- Shared package t1_pcs_pkg holds:
  - ternary encoding constants T_POS/T_ZERO/T_NEG;
  - the state enum;
  - the SSD/ESD/underrun-ESD pair constant arrays;
  - the Sy tap indices.
- One sub-module, t1_3b2t_map: combinational Sd[2:0] -> {ta,tb}, shared with the receive-side demapper checker.

## Test plan
- Reset, scr=0, sym_en every cycle, in_valid=0 -> Sy=000, out (-1,-1) every symbol; in_ready=0; scr_adv mirrors sym_en.
- scr with only bit0 set, IDLE -> Sy=001, out (-1,0). scr with bits 3,6 set -> Sy=110, out (+1,+1).
- One-group frame: in_data=101, in_last=1, scr=0 → sequence (0,0)x3, (+1,0), (0,0),(0,0),(+1,+1), then idle (-1,-1). in_ready is high exactly once.
- Underrun: SSD then 2 groups, in_valid drops → underrun pulse; (0,0),(0,0),(-1,-1); return to IDLE.
- sym_en every 3rd cycle during a frame → outputs change only one clk after each strobe. No group is consumed without a strobe.
- rst_n asserted mid-DATA → outputs 00/00 and out_valid=0 asynchronously. The first symbol after release is idle, with no ESD.
